sc_sng_bank: RTL and testbench
==============================

Name: sc_sng_bank

Overview:
- Parallel stochastic number generator (binary-to-stochastic encoder) that produces the N-lane bitstream bus consumed by the APC neuron and the other SC arithmetic blocks.
- Accepts one frame of N unsigned W-bit values over a valid/ready handshake.
- Emits N unipolar bitstreams of exactly 2**W-1 cycles. Lane i carries exactly value[i] ones per frame.
- Sits between the binary host/weight-load logic and the SC datapath.

Parameters:
- K, 3, log2 of lane count
- N, 2**K, number of parallel bitstream lanes
- W, 8, value precision and LFSR width; legal 4..16

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  frame values present on load_value
- load_ready  out  1  block can accept a frame this cycle
- load_value  in  N*W  lane i value = load_value[i*W +: W], unsigned
- dout  out  N  stochastic bitstreams, lane i on dout[i]
- dout_valid  out  1  dout carries a frame bit this cycle
- frame_done  out  1  one-cycle pulse on the last valid bit of a frame

Behaviour:
- Reset (reset low, async):
  - state=IDLE; LFSR=1 (seed); value regs=0; cycle counter=0.
  - Outputs: load_ready=1, dout=0, dout_valid=0, frame_done=0.
- States:
  - IDLE: load_ready=1; dout=0; LFSR holds.
  - RUN: dout_valid=1; LFSR steps every cycle; counter increments from 0 to 2**W-2.
- Transitions:
  - IDLE->RUN on handshake (load_valid & load_ready); values are latched at that edge.
  - RUN, counter==2**W-2: frame_done=1 and load_ready=1.
    - Handshake this cycle: stay in RUN, latch new values, counter=0. Back-to-back frames, no bubble.
    - Otherwise: go to IDLE.
  - In RUN with counter<2**W-2: load_ready=0; load_valid is ignored.
- Latency: first valid bit appears the cycle after the accepting edge. A frame is exactly 2**W-1 consecutive dout_valid cycles.
- LFSR:
  - Fibonacci, maximal length, never zero; next = {q[W-2:0], fb}.
  - W=8 taps: fb = q[7]^q[5]^q[4]^q[3].
  - Period 2**W-1, so the LFSR is back at seed 1 at every frame boundary. Frames are bit-exact repeatable.
- Lane random r_i = LFSR rotated left by (i mod W). Rotation is a bijection on nonzero values, so each lane still sees every value 1..2**W-1 once per frame.
- dout[i] = (r_i <= value_i), combinational from registers; dout is gated to 0 when dout_valid=0.
- Exactness:
  - value 0 -> 0 ones.
  - value 2**W-1 -> all ones.
  - value v -> exactly v ones per frame.
- Comparison is unsigned, W bits; no overflow path.
- Reset mid-frame: immediate abort to the IDLE reset values; the partial frame is discarded and no frame_done is issued.
- load_value may change freely when no handshake occurs; only values sampled at a handshake are used.

Optional Feature:
- Macro: SC_SNG_LANE_ROTATE_EN.
- Defined: per-lane rotation as above (decorrelated lanes, for multiply/APC use).
- Undefined: r_i = LFSR for all lanes (maximally correlated streams, for min/max/subtract gates). Per-lane ones counts are unchanged; dout[i] ones are a superset of dout[j] ones whenever value_i >= value_j.

Decomposition:
- Shared package sc_pkg:
  - state enum (IDLE, RUN)
  - function returning the LFSR tap mask for W=4..16
  - constant LFSR_SEED=1
- Sub-module sc_lfsr (parameter W; ports clk, reset, en, q).
- The lane rotate/compare stays in a generate loop in the top.

Test Plan:
- Reset then load all lanes 8'h00/8'hFF alternating -> 255 dout_valid cycles; even lanes 0 ones, odd lanes 255 ones; frame_done on cycle 255 only.
- Lane i value = 32*i+1 -> per-lane ones counts exactly 1,33,...,225. Rerun the same frame -> identical bit sequence.
- load_valid held high with a new frame ready at frame end -> zero-bubble RUN, dout_valid continuous for 510 cycles, two frame_done pulses 255 apart.
- load_valid asserted mid-frame (counter=100) with different values -> ignored, load_ready=0, current frame counts unchanged.
- reset asserted at counter=50 -> outputs 0 asynchronously, load_ready=1. Next load of value 128 yields exactly 128 ones.
- Build without SC_SNG_LANE_ROTATE_EN, lanes 64 and 192 -> every cycle with dout[lane64]=1 also has dout[lane192]=1. With the macro defined -> lane counts still 64/192.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic number generator bank:
// FSM state encoding, LFSR seed and the maximal-length tap table.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_e;

    localparam int LFSR_SEED = 1;

    // Tap mask for a left-shifting Fibonacci LFSR: fb = ^(q & mask).
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/sc_sng_bank_if.sv
// Load handshake and bitstream output bundle of sc_sng_bank.
interface sc_sng_bank_if #(
    parameter int K = 3,
    parameter int W = 8,
    parameter int N = 2**K
);
    logic           load_valid;
    logic           load_ready;
    logic [N*W-1:0] load_value;
    logic [N-1:0]   dout;
    logic           dout_valid;
    logic           frame_done;

    modport slave (
        input  load_valid, load_value,
        output load_ready, dout, dout_valid, frame_done
    );

    modport master (
        output load_valid, load_value,
        input  load_ready, dout, dout_valid, frame_done
    );
endinterface

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR, seeded to LFSR_SEED, stepping while en is high.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = {q_q[W-2:0], ^(q_q & TAPS)};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_q <= W'(LFSR_SEED);
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/sc_sng_bank.sv
// N-lane binary-to-stochastic encoder: each lane emits value[i] ones per 2**W-1 cycle frame.
// Define SC_SNG_LANE_ROTATE_EN to rotate the shared LFSR per lane (decorrelated lanes).
module sc_sng_bank
    import sc_pkg::*;
#(
    parameter int K = 3,
    parameter int N = 2**K,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    sc_sng_bank_if.slave bus
);
    localparam logic [W-1:0] LAST = W'((2**W) - 2);

    sc_state_e    state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] val_q [N];
    logic [W-1:0] val_d [N];
    logic [W-1:0] lfsr;
    logic         running;
    logic         at_last;
    logic         accept;

    assign running = (state_q == RUN);
    assign at_last = running && (cnt_q == LAST);
    assign accept  = bus.load_valid && bus.load_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        val_d          = val_q;
        bus.load_ready = 1'b0;
        bus.dout_valid = 1'b0;
        bus.frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    for (int i = 0; i < N; i++) val_d[i] = bus.load_value[i*W +: W];
                end
            end
            RUN: begin
                bus.dout_valid = 1'b1;
                bus.frame_done = at_last;
                bus.load_ready = at_last;
                if (at_last) begin
                    cnt_d = '0;
                    if (bus.load_valid) begin
                        for (int i = 0; i < N; i++) val_d[i] = bus.load_value[i*W +: W];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the value registers are plain flops, so they are reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) val_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

    // Stepping every RUN cycle brings the LFSR back to its seed at each frame boundary.
    sc_lfsr #(.W(W)) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .en   (running),
        .q    (lfsr)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] r;
`ifdef SC_SNG_LANE_ROTATE_EN
        localparam int ROT = i % W;
        if (ROT == 0) begin : g_norot
            assign r = lfsr;
        end else begin : g_rot
            assign r = {lfsr[W-1-ROT:0], lfsr[W-1:W-ROT]};
        end
`else
        assign r = lfsr;
`endif
        assign bus.dout[i] = running && (r <= val_q[i]);
    end
endmodule

// File: tb/tb_sc_sng_bank.sv
// Directed self-checking bench for sc_sng_bank (K=3, W=8) with a cycle-level reference model.
module tb_sc_sng_bank;
    localparam int K = 3;
    localparam int N = 8;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sc_sng_bank_if #(.K(K), .W(W), .N(N)) bus ();

    sc_sng_bank #(.K(K), .N(N), .W(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int       ones [N];
    int       valid_cycles, runs, done_count, model_err, gate_err, superset_err;
    int       done_at [4];
    logic     prev_valid;
    logic [N-1:0] exp_b;

    logic [7:0] ref_lfsr;
    int         ref_cnt;
    logic [7:0] ref_vals [N];
    logic [7:0] ref_next [N];
    bit         has_next;

    logic [7:0] va [N];
    logic [7:0] vb [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (8 - s));
    endfunction

    function automatic int lane_rot(input int i);
`ifdef SC_SNG_LANE_ROTATE_EN
        return i % W;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [N*W-1:0] pack(input logic [7:0] v [N]);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = v[i];
        return p;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < N; i++) ones[i] = 0;
        for (int i = 0; i < 4; i++) done_at[i] = -1;
        valid_cycles = 0;
        runs         = 0;
        done_count   = 0;
        model_err    = 0;
        gate_err     = 0;
        superset_err = 0;
    endtask

    // Called at a negedge while the DUT is idle; the frame is accepted at the next posedge.
    task automatic start_frame(input logic [7:0] v [N]);
        bus.load_value = pack(v);
        bus.load_valid = 1'b1;
        ref_vals       = v;
        ref_cnt        = 0;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_value = {$urandom, $urandom};
    endtask

    task automatic observe(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                if (prev_valid !== 1'b1) runs++;
                for (int i = 0; i < N; i++) begin
                    ones[i] += int'(bus.dout[i]);
                    exp_b[i] = (rotl(ref_lfsr, lane_rot(i)) <= ref_vals[i]);
                end
                if (bus.dout !== exp_b) model_err++;
                if (bus.frame_done !== (ref_cnt == 254)) model_err++;
                if (bus.load_ready !== (ref_cnt == 254)) model_err++;
                if (bus.frame_done === 1'b1) begin
                    if (done_count < 4) done_at[done_count] = valid_cycles;
                    done_count++;
                end
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        if (ref_vals[i] >= ref_vals[j] && bus.dout[j] === 1'b1 && bus.dout[i] !== 1'b1)
                            superset_err++;
                valid_cycles++;
                ref_lfsr = lfsr_next(ref_lfsr);
                if (ref_cnt == 254) begin
                    ref_cnt = 0;
                    if (has_next) begin
                        ref_vals = ref_next;
                        has_next = 0;
                    end
                end else begin
                    ref_cnt++;
                end
            end else begin
                if (bus.dout !== '0) gate_err++;
                if (bus.frame_done !== 1'b0) gate_err++;
                if (bus.load_ready !== 1'b1) gate_err++;
            end
            prev_valid = bus.dout_valid;
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        prev_valid     = 1'b0;
        ref_lfsr       = 8'd1;
        ref_cnt        = 0;
        has_next       = 0;
        clear_stats();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_dout",       32'(bus.dout),       32'd0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 00/FF alternating lanes
        for (int i = 0; i < N; i++) va[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
        clear_stats();
        start_frame(va);
        observe(260);
        check("alt_valid_cycles", 32'(valid_cycles), 32'd255);
        check("alt_runs",         32'(runs),         32'd1);
        check("alt_done_count",   32'(done_count),   32'd1);
        check("alt_done_pos",     32'(done_at[0]),   32'd254);
        check("alt_model",        32'(model_err),    32'd0);
        check("alt_idle_gate",    32'(gate_err),     32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("alt_ones_lane%0d", i), 32'(ones[i]), (i % 2 == 1) ? 32'd255 : 32'd0);

        // Lane i = 32*i+1, run twice for repeatability
        for (int i = 0; i < N; i++) va[i] = 8'(32 * i + 1);
        for (int p = 0; p < 2; p++) begin
            clear_stats();
            start_frame(va);
            observe(258);
            check($sformatf("ramp%0d_model", p), 32'(model_err),    32'd0);
            check($sformatf("ramp%0d_done",  p), 32'(done_count),   32'd1);
            check($sformatf("ramp%0d_valid", p), 32'(valid_cycles), 32'd255);
            for (int i = 0; i < N; i++)
                check($sformatf("ramp%0d_ones_lane%0d", p, i), 32'(ones[i]), 32'(32 * i + 1));
        end

        // Back-to-back frames with load_valid held high
        for (int i = 0; i < N; i++) begin
            va[i] = 8'(32 * i + 1);
            vb[i] = 8'(255 - 32 * i);
        end
        clear_stats();
        bus.load_value = pack(va);
        bus.load_valid = 1'b1;
        ref_vals       = va;
        ref_cnt        = 0;
        @(posedge clk);
        #1;
        bus.load_value = pack(vb);
        ref_next       = vb;
        has_next       = 1;
        observe(255);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_value = {$urandom, $urandom};
        observe(258);
        check("b2b_valid_cycles", 32'(valid_cycles), 32'd510);
        check("b2b_runs",         32'(runs),         32'd1);
        check("b2b_done_count",   32'(done_count),   32'd2);
        check("b2b_done0_pos",    32'(done_at[0]),   32'd254);
        check("b2b_done1_pos",    32'(done_at[1]),   32'd509);
        check("b2b_model",        32'(model_err),    32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("b2b_ones_lane%0d", i), 32'(ones[i]), 32'd256);

        // load_valid raised mid-frame is ignored
        for (int i = 0; i < N; i++) begin
            va[i] = 8'(10 * (i + 1));
            vb[i] = 8'(200 + i);
        end
        clear_stats();
        start_frame(va);
        observe(100);
        bus.load_value = pack(vb);
        bus.load_valid = 1'b1;
        observe(1);
        check("mid_load_ready", 32'(bus.load_ready), 32'd0);
        observe(4);
        bus.load_valid = 1'b0;
        observe(160);
        check("mid_valid_cycles", 32'(valid_cycles),   32'd255);
        check("mid_done_count",   32'(done_count),     32'd1);
        check("mid_model",        32'(model_err),      32'd0);
        check("mid_end_idle",     32'(bus.dout_valid), 32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("mid_ones_lane%0d", i), 32'(ones[i]), 32'(10 * (i + 1)));

        // Asynchronous reset at counter 50
        for (int i = 0; i < N; i++) va[i] = 8'hAA;
        clear_stats();
        start_frame(va);
        observe(51);
        check("rst50_done_before", 32'(done_count), 32'd0);
        reset = 1'b0;
        #1;
        check("rst50_dout",       32'(bus.dout),       32'd0);
        check("rst50_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst50_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst50_frame_done", 32'(bus.frame_done), 32'd0);
        ref_lfsr   = 8'd1;
        ref_cnt    = 0;
        prev_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) va[i] = 8'd128;
        clear_stats();
        start_frame(va);
        observe(258);
        check("post_rst_valid", 32'(valid_cycles), 32'd255);
        check("post_rst_model", 32'(model_err),    32'd0);
        check("post_rst_gate",  32'(gate_err),     32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("post_rst_ones_lane%0d", i), 32'(ones[i]), 32'd128);

        // Idle noise on load_value, then lanes 64/192 correlation
        clear_stats();
        for (int c = 0; c < 3; c++) begin
            bus.load_value = {$urandom, $urandom};
            observe(1);
        end
        check("idle_noise_gate", 32'(gate_err), 32'd0);
        for (int i = 0; i < N; i++) va[i] = 8'(32 * i);
        va[0] = 8'd64;
        va[1] = 8'd192;
        clear_stats();
        start_frame(va);
        observe(258);
        check("corr_ones_lane0", 32'(ones[0]),   32'd64);
        check("corr_ones_lane1", 32'(ones[1]),   32'd192);
        check("corr_model",      32'(model_err), 32'd0);
        check("corr_gate",       32'(gate_err),  32'd0);
`ifndef SC_SNG_LANE_ROTATE_EN
        check("corr_superset",   32'(superset_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
